// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues word-address fetches, tracks outstanding
// requests, buffers in-order responses and feeds the IF/ID register.
// Redirects flush the buffer and discard responses still in flight.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        StallD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        ValidD,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [CW:0]   sum_t;
    typedef logic [PW-1:0] ptr_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    localparam sum_t DEPTH_S = sum_t'(DEPTH);
    localparam ptr_t LAST    = ptr_t'(DEPTH - 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] pcF;
    logic [31:0] rspPC;
    entry_t      fifoMem [DEPTH];
    ptr_t        rdPtr, wrPtr;
    cnt_t        bufCount;
    cnt_t        outstanding;
    cnt_t        dropCnt;
    cnt_t        outNext;

    logic reqFire, rspFire, rspDrop, push, pop;
    entry_t head;

    function automatic ptr_t ptrInc(input ptr_t p);
        return (p == LAST) ? '0 : p + ptr_t'(1);
    endfunction

    // Request gating depends only on registered state; every accepted
    // request is guaranteed a buffer slot for its response.
    always_comb begin
        imem_req_valid = !reset &&
                         ((sum_t'(outstanding) + sum_t'(bufCount)) < DEPTH_S);
        imem_req_addr  = pcF;
        reqFire        = imem_req_valid && imem_req_ready;
        // Responses with nothing outstanding belong to pre-reset requests.
        rspFire        = imem_rsp_valid && (outstanding != '0);
        rspDrop        = rspFire && (PCSrcE || (dropCnt != '0));
        push           = rspFire && !rspDrop;
        pop            = !PCSrcE && !StallD && (bufCount != '0);
        outNext        = outstanding + cnt_t'(reqFire) - cnt_t'(rspFire);
        head           = fifoMem[rdPtr];
    end

    // PC, response PC, FIFO pointers and in-flight/drop bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcF         <= RESET_PC;
            rspPC       <= RESET_PC;
            rdPtr       <= '0;
            wrPtr       <= '0;
            bufCount    <= '0;
            outstanding <= '0;
            dropCnt     <= '0;
        end else begin
            outstanding <= outNext;
            if (PCSrcE) begin
                // Anything still in flight after this edge is stale.
                pcF      <= PCTargetE;
                rspPC    <= PCTargetE;
                rdPtr    <= '0;
                wrPtr    <= '0;
                bufCount <= '0;
                dropCnt  <= outNext;
            end else begin
                if (reqFire) pcF <= pcF + 32'd1;
                if (rspDrop) dropCnt <= dropCnt - cnt_t'(1);
                if (push) begin
                    wrPtr <= ptrInc(wrPtr);
                    rspPC <= rspPC + 32'd1;
                end
                if (pop) rdPtr <= ptrInc(rdPtr);
                bufCount <= bufCount + cnt_t'(push) - cnt_t'(pop);
            end
        end
    end

    // FIFO storage: data only, no reset needed since bufCount guards reads.
    always_ff @(posedge clk) begin
        if (push) fifoMem[wrPtr] <= '{instr: imem_rsp_data, pc: rspPC};
    end

    // IF/ID register: redirect beats stall; empty buffer bubbles Decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ValidD   <= 1'b0;
            InstrD   <= NOP;
            PCD      <= 32'h0;
            PCPlus4D <= 32'h0;
        end else if (PCSrcE) begin
            ValidD <= 1'b0;
        end else if (!StallD) begin
            if (bufCount != '0) begin
                ValidD   <= 1'b1;
                InstrD   <= head.instr;
                PCD      <= head.pc;
                PCPlus4D <= head.pc + 32'd1;
            end else begin
                ValidD <= 1'b0;
            end
        end
    end

endmodule
